dds_pwm_nco: RTL and testbench

Parametrised numerically controlled oscillator for the SquareWave subsystem. It generalises the fixed 24-bit, 50 %-duty square-wave DDS with configurable accumulator width, programmable duty cycle and phase offset, and a run enable. A valid/ready configuration port takes new settings, which are applied only at an accumulator wrap so the output never glitches. It drives the serial/FIFO logic with a square/PWM wave plus single-cycle rise, fall and wrap strobes.

---
 rtl/dds_pkg.sv | 14 +
 rtl/dds_cfg_shadow.sv | 52 +++++
 rtl/dds_pwm_nco.sv | 65 ++++++
 tb/tb_dds_pwm_nco.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// dds_pkg: shared defaults, configuration record and reset-duty helper for the DDS/PWM NCO.
package dds_pkg;
    localparam int DEF_ACC_W = 32;
    localparam int DEF_DUTY_W = 8;
    typedef struct packed {
        logic [DEF_ACC_W-1:0] f_word;
        logic [DEF_DUTY_W-1:0] duty;
        logic [DEF_ACC_W-1:0] phase;
    } dds_cfg_t;
    localparam logic [DEF_DUTY_W-1:0] DUTY_RST = DEF_DUTY_W'(1) << (DEF_DUTY_W - 1);
    function automatic logic [31:0] duty_rst(input int w);
        return 32'd1 << (w - 1);
    endfunction
endpackage

// File: rtl/dds_cfg_shadow.sv
// dds_cfg_shadow: valid/ready capture into shadow registers, applied to the active set at a wrap or while idle.
module dds_cfg_shadow import dds_pkg::*; #(
    parameter int ACC_W = DEF_ACC_W,
    parameter int DUTY_W = DEF_DUTY_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              carry,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              cfg_pending,
    input  logic [ACC_W-1:0]  cfg_f_word,
    input  logic [DUTY_W-1:0] cfg_duty,
    input  logic [ACC_W-1:0]  cfg_phase,
    output logic [ACC_W-1:0]  f_act,
    output logic [ACC_W-1:0]  phase_sel,
    output logic [DUTY_W-1:0] duty_sel
);
    logic pend, apply;
    logic [ACC_W-1:0] f_sh, phase_sh, phase_act;
    logic [DUTY_W-1:0] duty_sh, duty_act;
    assign cfg_ready = ~pend;
    assign cfg_pending = pend;
    assign apply = pend & (~en | carry);
    // Compare values must be those in force after this edge so wave tracks acc.
    always_comb begin
        phase_sel = apply ? phase_sh : phase_act;
        duty_sel = apply ? duty_sh : duty_act;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            pend <= 1'b0;
            f_sh <= '0;
            duty_sh <= '0;
            phase_sh <= '0;
            f_act <= '0;
            duty_act <= DUTY_W'(duty_rst(DUTY_W));
            phase_act <= '0;
        end else if (cfg_valid && cfg_ready) begin
            f_sh <= cfg_f_word;
            duty_sh <= cfg_duty;
            phase_sh <= cfg_phase;
            pend <= 1'b1;
        end else if (apply) begin
            f_act <= f_sh;
            duty_act <= duty_sh;
            phase_act <= phase_sh;
            pend <= 1'b0;
        end
    end
endmodule

// File: rtl/dds_pwm_nco.sv
// dds_pwm_nco: phase-accumulator NCO producing a PWM/square wave with rise, fall and wrap strobes.
module dds_pwm_nco import dds_pkg::*; #(
    parameter int ACC_W = DEF_ACC_W,
    parameter int DUTY_W = DEF_DUTY_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [ACC_W-1:0]  cfg_f_word,
    input  logic [DUTY_W-1:0] cfg_duty,
    input  logic [ACC_W-1:0]  cfg_phase,
    output logic              wave,
    output logic              rise_stb,
    output logic              fall_stb,
    output logic              wrap_stb,
    output logic              cfg_pending
);
    logic [ACC_W-1:0] acc, acc_nx, f_act, phase_sel, pos;
    logic [DUTY_W-1:0] duty_sel;
    logic carry, wave_nx;
    dds_cfg_shadow #(.ACC_W(ACC_W), .DUTY_W(DUTY_W)) u_shadow (
        .clk(clk),
        .rst(rst),
        .en(en),
        .carry(carry),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_pending(cfg_pending),
        .cfg_f_word(cfg_f_word),
        .cfg_duty(cfg_duty),
        .cfg_phase(cfg_phase),
        .f_act(f_act),
        .phase_sel(phase_sel),
        .duty_sel(duty_sel)
    );
    always_comb begin
        {carry, acc_nx} = {1'b0, acc} + {1'b0, f_act};
        pos = acc_nx + phase_sel;
        wave_nx = pos[ACC_W-1 -: DUTY_W] < duty_sel;
    end
    // Idle forces wave low; fall_stb still reports a drop from high.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            wave <= 1'b0;
            rise_stb <= 1'b0;
            fall_stb <= 1'b0;
            wrap_stb <= 1'b0;
        end else if (!en) begin
            acc <= '0;
            wave <= 1'b0;
            rise_stb <= 1'b0;
            fall_stb <= wave;
            wrap_stb <= 1'b0;
        end else begin
            acc <= acc_nx;
            wave <= wave_nx;
            rise_stb <= wave_nx & ~wave;
            fall_stb <= ~wave_nx & wave;
            wrap_stb <= carry;
        end
    end
endmodule

// File: tb/tb_dds_pwm_nco.sv
// tb_dds_pwm_nco: directed vectors with hand-computed wave/wrap sequences for an 8-bit accumulator, 4-bit duty NCO.
module tb_dds_pwm_nco;
    localparam int AW = 8;
    localparam int DW = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic cfg_valid = 1'b0;
    logic [AW-1:0] cfg_f_word = '0;
    logic [DW-1:0] cfg_duty = '0;
    logic [AW-1:0] cfg_phase = '0;
    logic cfg_ready, wave, rise_stb, fall_stb, wrap_stb, cfg_pending;
    int checks = 0;
    int failures = 0;
    logic exp_prev = 1'b0;

    always #5 clk = ~clk;

    dds_pwm_nco #(.ACC_W(AW), .DUTY_W(DW)) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .cfg_f_word(cfg_f_word),
        .cfg_duty(cfg_duty),
        .cfg_phase(cfg_phase),
        .wave(wave),
        .rise_stb(rise_stb),
        .fall_stb(fall_stb),
        .wrap_stb(wrap_stb),
        .cfg_pending(cfg_pending)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Strings give the expected wave and wrap per cycle; edge strobes follow from the expected wave.
    task automatic run(input string tag, input string w, input string wr);
        for (int i = 0; i < w.len(); i++) begin
            logic ew;
            ew = (w[i] == "1");
            tick();
            chk($sformatf("%s[%0d] wave", tag, i), wave, ew);
            chk($sformatf("%s[%0d] rise", tag, i), rise_stb, ew & ~exp_prev);
            chk($sformatf("%s[%0d] fall", tag, i), fall_stb, ~ew & exp_prev);
            chk($sformatf("%s[%0d] wrap", tag, i), wrap_stb, wr[i] == "1");
            exp_prev = ew;
        end
    endtask

    task automatic offer(input logic [AW-1:0] f, input logic [DW-1:0] d, input logic [AW-1:0] p);
        cfg_f_word = f;
        cfg_duty = d;
        cfg_phase = p;
        cfg_valid = 1'b1;
    endtask

    initial begin
        tick();
        tick();
        chk("rst wave", wave, 0);
        chk("rst rise", rise_stb, 0);
        chk("rst fall", fall_stb, 0);
        chk("rst wrap", wrap_stb, 0);
        chk("rst ready", cfg_ready, 1);
        chk("rst pend", cfg_pending, 0);
        rst = 1'b0;
        en = 1'b1;
        // f=0 freezes acc at 0, which lies below the default half-scale duty threshold.
        run("f0", "11111111", "00000000");
        chk("f0 ready", cfg_ready, 1);
        chk("f0 pend", cfg_pending, 0);
        en = 1'b0;
        run("idle", "0", "0");
        offer(8'h20, 4'd8, 8'h00);
        run("cfg20", "0", "0");
        cfg_valid = 1'b0;
        chk("cfg20 pend", cfg_pending, 1);
        chk("cfg20 ready", cfg_ready, 0);
        run("app20", "0", "0");
        chk("app20 pend", cfg_pending, 0);
        chk("app20 ready", cfg_ready, 1);
        en = 1'b1;
        run("f20", "1110000111100001", "0000000100000001");
        offer(8'h40, 4'd8, 8'h00);
        run("acc40", "1", "0");
        cfg_valid = 1'b0;
        chk("acc40 ready", cfg_ready, 0);
        chk("acc40 pend", cfg_pending, 1);
        run("hold40", "110000", "000000");
        chk("hold40 ready", cfg_ready, 0);
        run("wrap40", "1", "1");
        chk("wrap40 ready", cfg_ready, 1);
        chk("wrap40 pend", cfg_pending, 0);
        run("f40", "10011001", "00010001");
        en = 1'b0;
        run("stop1", "0", "0");
        offer(8'h10, 4'd0, 8'h00);
        run("cfgd0", "0", "0");
        cfg_valid = 1'b0;
        run("appd0", "0", "0");
        en = 1'b1;
        run("duty0", "00000000000000000000", "00000000000000010000");
        en = 1'b0;
        run("stop2", "0", "0");
        offer(8'h10, 4'd15, 8'h00);
        run("cfgd15", "0", "0");
        cfg_valid = 1'b0;
        run("appd15", "0", "0");
        en = 1'b1;
        run("duty15", "11111111111111011111111111111101", "00000000000000010000000000000001");
        en = 1'b0;
        run("stop3", "0", "0");
        offer(8'h20, 4'd8, 8'h80);
        run("cfgph", "0", "0");
        cfg_valid = 1'b0;
        run("appph", "0", "0");
        en = 1'b1;
        run("ph80", "0001111000011110", "0000000100000001");
        offer(8'h40, 4'd8, 8'h00);
        run("rstcfg", "0", "0");
        cfg_valid = 1'b0;
        chk("rstcfg pend", cfg_pending, 1);
        rst = 1'b1;
        tick();
        chk("midrst wave", wave, 0);
        chk("midrst rise", rise_stb, 0);
        chk("midrst fall", fall_stb, 0);
        chk("midrst wrap", wrap_stb, 0);
        chk("midrst ready", cfg_ready, 1);
        chk("midrst pend", cfg_pending, 0);
        rst = 1'b0;
        exp_prev = 1'b0;
        run("postrst", "111111111111", "000000000000");
        chk("postrst pend", cfg_pending, 0);
        chk("postrst ready", cfg_ready, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
